spi_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one SPI master (16-bit `wrt`/`cmd`/`done`/`rd_data` interface) between up to `NUM_REQ` requesters. Each requester posts a 16-bit command; the arbiter selects one, launches it on the master, detects completion, and returns the 16-bit read data to that requester. It also enforces a programmable idle gap between back-to-back transactions. It sits between the sensor-polling/command logic and the SPI master.

---
 rtl/spi_arb_pkg.sv | 14 +
 rtl/spi_arb_rr_pick.sv | 39 +++
 rtl/spi_arb.sv | 123 ++++++++++++
 tb/tb_spi_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared state encoding and widths for the SPI master arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } arb_state_t;

  localparam int CMD_W = 16;
  localparam int GAP_W = 8;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, with wrap-around.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [IDX_W:0]       idx;
  logic                 found;

  // Doubling the vector turns the wrap-around search into a linear scan from ptr_i.
  assign dbl   = {req_i, req_i};
  assign any_o = |req_i;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (!found && dbl[idx]) begin
        found = 1'b1;
        if (idx >= (IDX_W+1)'(NUM_REQ)) begin
          winner_o = IDX_W'(idx - (IDX_W+1)'(NUM_REQ));
        end else begin
          winner_o = IDX_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Shares one SPI master between NUM_REQ requesters: round-robin accept, launch,
// edge-detected completion, response return and a fixed idle gap between transactions.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYC = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [CMD_W*NUM_REQ-1:0] req_cmd_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       rsp_vld_o,
  output logic [CMD_W-1:0]         rsp_data_o,
  output logic                     busy_o,
  output logic                     wrt_o,
  output logic [CMD_W-1:0]         cmd_o,
  input  logic                     done_i,
  input  logic [CMD_W-1:0]         rd_data_i
);

  localparam int                 IDX_W    = $clog2(NUM_REQ);
  localparam logic [GAP_W-1:0]   GAP_LOAD = (GAP_CYC == 0) ? '0 : GAP_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_t           state_q;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, winner_q, pick;
  logic                 pick_any, done_q, done_rise;
  logic [GAP_W-1:0]     gap_q;
  logic [CMD_W-1:0]     pick_cmd, cmd_q, rsp_data_q;
  logic [NUM_REQ-1:0]   gnt_q, rsp_vld_q;
  logic                 wrt_q, busy_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick),
    .any_o    (pick_any)
  );

  always_comb begin
    pick_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) pick_cmd = req_cmd_i[i*CMD_W +: CMD_W];
    end
  end

  assign rr_ptr_d = (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;
  // done stays high from the previous transaction, so only a fresh rising edge completes.
  assign done_rise = done_i & ~done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      winner_q   <= '0;
      done_q     <= 1'b0;
      gap_q      <= '0;
      cmd_q      <= '0;
      rsp_data_q <= '0;
      wrt_q      <= 1'b0;
      gnt_q      <= '0;
      rsp_vld_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      done_q    <= done_i;
      wrt_q     <= 1'b0;
      gnt_q     <= '0;
      rsp_vld_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            winner_q <= pick;
            cmd_q    <= pick_cmd;
            wrt_q    <= 1'b1;
            gnt_q    <= ONE_HOT0 << pick;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_rise) begin
            rsp_data_q <= rd_data_i;
            rsp_vld_q  <= ONE_HOT0 << winner_q;
            gap_q      <= GAP_LOAD;
            if (GAP_CYC == 0) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign rsp_vld_o  = rsp_vld_q;
  assign rsp_data_o = rsp_data_q;
  assign busy_o     = busy_q;
  assign wrt_o      = wrt_q;
  assign cmd_o      = cmd_q;

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: two instances (GAP_CYC=8 and 0) share one SPI master model.
module tb_spi_arb;

  localparam int N     = 4;
  localparam int CW    = 16;
  localparam int GAP_A = 8;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic [N-1:0]    req;
  logic [CW*N-1:0] reqCmd;
  logic            done;
  logic [CW-1:0]   rdData;

  logic [N-1:0]  reqA, reqB, gntA, gntB, rspA, rspB, gnt, rsp;
  logic [CW-1:0] rdA, rdB, cmdA, cmdB, rspData, cmd;
  logic          busyA, busyB, wrtA, wrtB, busy, wrt;

  int total, bad, refPtr;
  int clrDly, latDly, clrCnt, latCnt, phase;
  logic [CW-1:0] spiCmd;
  logic prevDone;

  always #5 clk = ~clk;

  assign reqA    = sel ? '0 : req;
  assign reqB    = sel ? req : '0;
  assign gnt     = sel ? gntB : gntA;
  assign rsp     = sel ? rspB : rspA;
  assign rspData = sel ? rdB : rdA;
  assign cmd     = sel ? cmdB : cmdA;
  assign busy    = sel ? busyB : busyA;
  assign wrt     = sel ? wrtB : wrtA;

  spi_arb #(.NUM_REQ(N), .GAP_CYC(GAP_A)) dutA (
    .clk_i(clk), .rst_i(rst), .req_i(reqA), .req_cmd_i(reqCmd),
    .gnt_o(gntA), .rsp_vld_o(rspA), .rsp_data_o(rdA), .busy_o(busyA),
    .wrt_o(wrtA), .cmd_o(cmdA), .done_i(done), .rd_data_i(rdData)
  );

  spi_arb #(.NUM_REQ(N), .GAP_CYC(0)) dutB (
    .clk_i(clk), .rst_i(rst), .req_i(reqB), .req_cmd_i(reqCmd),
    .gnt_o(gntB), .rsp_vld_o(rspB), .rsp_data_o(rdB), .busy_o(busyB),
    .wrt_o(wrtB), .cmd_o(cmdB), .done_i(done), .rd_data_i(rdData)
  );

  function automatic logic [CW-1:0] dataFor(input logic [CW-1:0] c);
    return c ^ 16'hB7F7;
  endfunction

  function automatic int refWinner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // SPI master model: done stays high from the last transfer for clrDly cycles after wrt,
  // then rises latDly cycles later with data derived from the command; junk while shifting.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0; rdData <= '0; phase <= 0; clrCnt <= 0; latCnt <= 0; spiCmd <= '0;
    end else if (wrt) begin
      spiCmd <= cmd; clrCnt <= clrDly; latCnt <= latDly; phase <= 1;
    end else if (phase == 1) begin
      if (clrCnt <= 1) begin done <= 1'b0; phase <= 2; end
      else clrCnt <= clrCnt - 1;
    end else if (phase == 2) begin
      rdData <= 16'($urandom);
      if (latCnt <= 1) begin done <= 1'b1; rdData <= dataFor(spiCmd); phase <= 0; end
      else latCnt <= latCnt - 1;
    end
  end

  task automatic step();
    prevDone = done;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [CW-1:0] c);
    req[i] = 1'b1;
    reqCmd[i*CW +: CW] = c;
  endtask

  task automatic doReset();
    rst = 1'b1; req = '0;
    step(); step();
    rst = 1'b0; refPtr = 0;
    step();
  endtask

  // One full transaction from the IDLE cycle through the end of the gap.
  task automatic serveOne(input logic [N-1:0] lateMask, input bit rearm, output logic [N-1:0] gntSeen);
    int g, gap;
    logic [N-1:0] oh;
    logic [CW-1:0] expCmd;
    bit seen;
    gap    = sel ? 0 : GAP_A;
    g      = refWinner(req, refPtr);
    oh     = N'(1) << g;
    expCmd = reqCmd[g*CW +: CW];
    step();
    gntSeen = gnt;
    checkOutput("gnt", 32'(gnt), 32'(oh));
    checkOutput("wrt_issue", 32'(wrt), 32'd1);
    checkOutput("cmd", 32'(cmd), 32'(expCmd));
    checkOutput("busy_issue", 32'(busy), 32'd1);
    checkOutput("rsp_excl", 32'(rsp), 32'd0);
    refPtr = (g + 1) % N;
    if (!rearm) req[g] = 1'b0;
    reqCmd[g*CW +: CW] = 16'($urandom);
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      step();
      if (t == 0) req = req | lateMask;
      checkOutput("no_early_rsp", 32'(rsp), 32'd0);
      checkOutput("wrt_wait", 32'(wrt), 32'd0);
      checkOutput("cmd_hold", 32'(cmd), 32'(expCmd));
      if (done && !prevDone) seen = 1'b1;
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    step();
    checkOutput("rsp_vld", 32'(rsp), 32'(oh));
    checkOutput("rsp_data", 32'(rspData), 32'(dataFor(expCmd)));
    checkOutput("gnt_excl", 32'(gnt), 32'd0);
    checkOutput("busy_rsp", 32'(busy), 32'(gap > 0));
    for (int k = 2; k <= gap + 1; k++) begin
      step();
      checkOutput("gap_wrt", 32'(wrt), 32'd0);
      checkOutput("gap_busy", 32'(busy), 32'(k <= gap));
      checkOutput("rsp_once", 32'(rsp), 32'd0);
      checkOutput("rsp_hold", 32'(rspData), 32'(dataFor(expCmd)));
    end
  endtask

  initial begin
    logic [N-1:0] gs, lm;
    int order [5] = '{0, 1, 2, 3, 0};
    total = 0; bad = 0; refPtr = 0; sel = 1'b0;
    req = '0; reqCmd = '0; clrDly = 1; latDly = 4;
    rst = 1'b1;
    step(); step();
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_rsp", 32'(rsp), 32'd0);
    checkOutput("rst_data", 32'(rspData), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wrt", 32'(wrt), 32'd0);
    checkOutput("rst_cmd", 32'(cmd), 32'd0);
    rst = 1'b0;
    step();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Single request from requester 1.
    applyStimulus(1, 16'hA5C3);
    serveOne('0, 1'b0, gs);
    checkOutput("single_gnt", 32'(gs), 32'h2);
    checkOutput("single_data", 32'(rspData), 32'h1234);
    step();
    checkOutput("idle_after", 32'(wrt), 32'd0);

    // All requesters continuously active after reset.
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(i, 16'($urandom));
    for (int n = 0; n < 5; n++) begin
      clrDly = $urandom_range(1, 3); latDly = $urandom_range(1, 6);
      serveOne('0, 1'b1, gs);
      checkOutput("rr_order", 32'(gs), 32'(N'(1) << order[n]));
    end
    req = '0;

    // Late request: requester 3 rises while requester 0 waits for done.
    doReset();
    clrDly = 4; latDly = 3;
    applyStimulus(0, 16'($urandom));
    reqCmd[3*CW +: CW] = 16'($urandom);
    serveOne(4'b1000, 1'b0, gs);
    serveOne('0, 1'b0, gs);
    checkOutput("late_gnt", 32'(gs), 32'h8);

    // Randomised traffic with stale done and varying latency.
    for (int n = 0; n < 20; n++) begin
      clrDly = $urandom_range(1, 4); latDly = $urandom_range(1, 8);
      for (int i = 0; i < N; i++) if (!req[i] && ($urandom % 3 == 0)) applyStimulus(i, 16'($urandom));
      if (req == '0) applyStimulus($urandom_range(0, N-1), 16'($urandom));
      lm = N'($urandom) & ~req;
      for (int i = 0; i < N; i++) if (lm[i]) reqCmd[i*CW +: CW] = 16'($urandom);
      serveOne(lm, 1'($urandom), gs);
    end
    req = '0;

    // Zero-gap instance.
    sel = 1'b1;
    doReset();
    for (int n = 0; n < 6; n++) begin
      clrDly = $urandom_range(1, 3); latDly = $urandom_range(1, 5);
      for (int i = 0; i < N; i++) if (!req[i] && ($urandom % 2 == 0)) applyStimulus(i, 16'($urandom));
      if (req == '0) applyStimulus($urandom_range(0, N-1), 16'($urandom));
      serveOne('0, 1'($urandom), gs);
    end
    req = '0;
    sel = 1'b0;

    // Reset during WAIT_DONE.
    doReset();
    clrDly = 1; latDly = 3;
    applyStimulus(2, 16'($urandom));
    serveOne('0, 1'b0, gs);
    latDly = 10;
    applyStimulus(1, 16'($urandom));
    step();
    checkOutput("pre_rst_gnt", 32'(gnt), 32'h2);
    req = '0;
    step();
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_gnt", 32'(gnt), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_cmd", 32'(cmd), 32'd0);
    checkOutput("arst_data", 32'(rspData), 32'd0);
    checkOutput("arst_wrt", 32'(wrt), 32'd0);
    #2 rst = 1'b0;
    refPtr = 0;
    for (int t = 0; t < 4; t++) begin
      step();
      checkOutput("post_rst_rsp", 32'(rsp), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
    end
    latDly = 3;
    applyStimulus(0, 16'($urandom));
    applyStimulus(3, 16'($urandom));
    serveOne('0, 1'b0, gs);
    checkOutput("post_rst_ptr", 32'(gs), 32'h1);
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
